// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared opcodes, state encoding and control codes for the multicycle controller
package riscv_ctrl_pkg;

  // Opcodes the controller understands (instr[6:0])
  localparam logic [6:0] op_load   = 7'b0000011;
  localparam logic [6:0] op_store  = 7'b0100011;
  localparam logic [6:0] op_rtype  = 7'b0110011;
  localparam logic [6:0] op_itype  = 7'b0010011;
  localparam logic [6:0] op_jal    = 7'b1101111;
  localparam logic [6:0] op_branch = 7'b1100011;

  // Controller states; 4 bits leaves room for growth
  typedef enum logic [3:0] {
    st_fetch    = 4'd0,
    st_decode   = 4'd1,
    st_memadr   = 4'd2,
    st_memread  = 4'd3,
    st_memwb    = 4'd4,
    st_memwrite = 4'd5,
    st_exec_r   = 4'd6,
    st_exec_i   = 4'd7,
    st_jal      = 4'd8,
    st_aluwb    = 4'd9,
    st_beq      = 4'd10,
    st_illegal  = 4'd11
  } state_t;

  // ALU operation codes
  localparam logic [2:0] alu_add = 3'b000;
  localparam logic [2:0] alu_sub = 3'b001;
  localparam logic [2:0] alu_and = 3'b010;
  localparam logic [2:0] alu_or  = 3'b011;
  localparam logic [2:0] alu_slt = 3'b101;

  // Coarse ALU request from the FSM to the ALU decoder
  localparam logic [1:0] aluop_add   = 2'b00;
  localparam logic [1:0] aluop_sub   = 2'b01;
  localparam logic [1:0] aluop_funct = 2'b10;

  // Immediate formats (sign_extend encoding)
  localparam logic [1:0] imm_i = 2'b00;
  localparam logic [1:0] imm_s = 2'b01;
  localparam logic [1:0] imm_b = 2'b10;
  localparam logic [1:0] imm_j = 2'b11;

  // ALU operand selects
  localparam logic [1:0] src_a_pc    = 2'b00;
  localparam logic [1:0] src_a_oldpc = 2'b01;
  localparam logic [1:0] src_a_rs1   = 2'b10;
  localparam logic [1:0] src_b_rs2   = 2'b00;
  localparam logic [1:0] src_b_imm   = 2'b01;
  localparam logic [1:0] src_b_four  = 2'b10;

  // Writeback result selects
  localparam logic [1:0] res_aluout = 2'b00;
  localparam logic [1:0] res_rdata  = 2'b01;
  localparam logic [1:0] res_alu    = 2'b10;

  // Immediate format implied by the opcode alone
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      op_store:  imm_src_of = imm_s;
      op_branch: imm_src_of = imm_b;
      op_jal:    imm_src_of = imm_j;
      default:   imm_src_of = imm_i;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps the FSM's coarse ALU request and funct fields to an ALU operation
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  // Only R-type (op5=1) with funct7b5 turns funct3=000 into a subtract
  always_comb begin
    alu_control = alu_add;
    case (alu_op)
      aluop_sub: alu_control = alu_sub;
      aluop_funct: begin
        case (funct3)
          3'b000:  alu_control = (op5 & funct7b5) ? alu_sub : alu_add;
          3'b010:  alu_control = alu_slt;
          3'b110:  alu_control = alu_or;
          3'b111:  alu_control = alu_and;
          default: alu_control = alu_add;
        endcase
      end
      default: alu_control = alu_add;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - control FSM sequencing fetch/decode/execute/memory/writeback
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter bit MEM_WAIT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       adr_src,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       pc_write,
  output logic [1:0] imm_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] result_src,
  output logic       instr_done,
  output logic       illegal
);

  state_t     state, state_next;
  logic       rdy;
  logic       pc_update, branch;
  logic [1:0] alu_op;
  logic [2:0] alu_ctl;
  logic       mem_req_c, adr_src_c, ir_write_c, mem_write_c, reg_write_c;
  logic       instr_done_c, illegal_c;
  logic [1:0] alu_src_a_c, alu_src_b_c, result_src_c;

  // With waits disabled the memory is assumed to answer in the request cycle
  assign rdy = MEM_WAIT ? mem_ready : 1'b1;

  // State register; reset forces FETCH regardless of any access in flight
  always_ff @(posedge clk) begin
    if (reset) state <= st_fetch;
    else       state <= state_next;
  end

  // Next-state selection
  always_comb begin
    state_next = state;
    case (state)
      st_fetch:    state_next = rdy ? st_decode : st_fetch;
      st_decode: begin
        case (op)
          op_load, op_store: state_next = st_memadr;
          op_rtype:          state_next = st_exec_r;
          op_itype:          state_next = st_exec_i;
          op_jal:            state_next = st_jal;
          op_branch:         state_next = st_beq;
          default:           state_next = st_illegal;
        endcase
      end
      st_memadr:   state_next = op[5] ? st_memwrite : st_memread;
      st_memread:  state_next = rdy ? st_memwb : st_memread;
      st_memwb:    state_next = st_fetch;
      st_memwrite: state_next = rdy ? st_fetch : st_memwrite;
      st_exec_r:   state_next = st_aluwb;
      st_exec_i:   state_next = st_aluwb;
      st_jal:      state_next = st_aluwb;
      st_aluwb:    state_next = st_fetch;
      st_beq:      state_next = st_fetch;
      st_illegal:  state_next = st_illegal;
      default:     state_next = st_fetch;
    endcase
  end

  // Per-state control decode; everything not named in a state stays low
  always_comb begin
    mem_req_c    = 1'b0;
    adr_src_c    = 1'b0;
    ir_write_c   = 1'b0;
    mem_write_c  = 1'b0;
    reg_write_c  = 1'b0;
    pc_update    = 1'b0;
    branch       = 1'b0;
    instr_done_c = 1'b0;
    illegal_c    = 1'b0;
    alu_src_a_c  = src_a_pc;
    alu_src_b_c  = src_b_rs2;
    alu_op       = aluop_add;
    result_src_c = res_aluout;
    case (state)
      st_fetch: begin
        mem_req_c    = 1'b1;
        alu_src_b_c  = src_b_four;
        result_src_c = res_alu;
        ir_write_c   = rdy;
        pc_update    = rdy;
      end
      st_decode: begin
        alu_src_a_c = src_a_oldpc;
        alu_src_b_c = src_b_imm;
      end
      st_memadr: begin
        alu_src_a_c = src_a_rs1;
        alu_src_b_c = src_b_imm;
      end
      st_memread: begin
        mem_req_c = 1'b1;
        adr_src_c = 1'b1;
      end
      st_memwb: begin
        result_src_c = res_rdata;
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
      end
      st_memwrite: begin
        mem_req_c    = 1'b1;
        adr_src_c    = 1'b1;
        mem_write_c  = 1'b1;
        instr_done_c = rdy;
      end
      st_exec_r: begin
        alu_src_a_c = src_a_rs1;
        alu_src_b_c = src_b_rs2;
        alu_op      = aluop_funct;
      end
      st_exec_i: begin
        alu_src_a_c = src_a_rs1;
        alu_src_b_c = src_b_imm;
        alu_op      = aluop_funct;
      end
      st_jal: begin
        alu_src_a_c = src_a_oldpc;
        alu_src_b_c = src_b_four;
        pc_update   = 1'b1;
      end
      st_aluwb: begin
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
      end
      st_beq: begin
        alu_src_a_c  = src_a_rs1;
        alu_src_b_c  = src_b_rs2;
        alu_op       = aluop_sub;
        branch       = 1'b1;
        instr_done_c = 1'b1;
      end
      st_illegal: illegal_c = 1'b1;
      default: ;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op5         (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (alu_ctl)
  );

  // Reset masks every output combinationally so nothing can pulse while it is held
  assign mem_req     = ~reset & mem_req_c;
  assign adr_src     = ~reset & adr_src_c;
  assign ir_write    = ~reset & ir_write_c;
  assign mem_write   = ~reset & mem_write_c;
  assign reg_write   = ~reset & reg_write_c;
  assign pc_write    = ~reset & (pc_update | (branch & zero));
  assign instr_done  = ~reset & instr_done_c;
  assign illegal     = ~reset & illegal_c;
  assign imm_src     = reset ? 2'b00  : imm_src_of(op);
  assign alu_src_a   = reset ? 2'b00  : alu_src_a_c;
  assign alu_src_b   = reset ? 2'b00  : alu_src_b_c;
  assign alu_control = reset ? 3'b000 : alu_ctl;
  assign result_src  = reset ? 2'b00  : result_src_c;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - randomized self-checking bench against a per-instruction cycle table
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero, mem_ready;
  logic       mem_req, adr_src, ir_write, mem_write, reg_write, pc_write;
  logic [1:0] imm_src, alu_src_a, alu_src_b, result_src;
  logic [2:0] alu_control;
  logic       instr_done, illegal;

  typedef struct packed {
    logic       mem_req, adr_src, ir_write, mem_write, reg_write, pc_write;
    logic [1:0] imm;
    logic [1:0] a, b;
    logic [2:0] alu;
    logic [1:0] rsrc;
    logic       done, illegal;
  } ctl_t;

  typedef struct packed {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7, z, rdy;
  } in_t;

  ctl_t exp_q[$];
  in_t  in_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic       cur_f7;
  logic [1:0] cur_imm;

  multicycle_controller #(.MEM_WAIT(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .adr_src(adr_src),
    .ir_write(ir_write), .mem_write(mem_write), .reg_write(reg_write),
    .pc_write(pc_write), .imm_src(imm_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_control(alu_control), .result_src(result_src),
    .instr_done(instr_done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic ctl_t observed();
    observed = {mem_req, adr_src, ir_write, mem_write, reg_write, pc_write,
                imm_src, alu_src_a, alu_src_b, alu_control, result_src,
                instr_done, illegal};
  endfunction

  task automatic check_ctl(input string tag, input ctl_t got, input ctl_t exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%b_%b_%b_%b_%b_%b imm=%b a=%b b=%b alu=%b rs=%b done=%b ill=%b exp=%b_%b_%b_%b_%b_%b imm=%b a=%b b=%b alu=%b rs=%b done=%b ill=%b",
             tag, got.mem_req, got.adr_src, got.ir_write, got.mem_write, got.reg_write,
             got.pc_write, got.imm, got.a, got.b, got.alu, got.rsrc, got.done, got.illegal,
             exp.mem_req, exp.adr_src, exp.ir_write, exp.mem_write, exp.reg_write,
             exp.pc_write, exp.imm, exp.a, exp.b, exp.alu, exp.rsrc, exp.done, exp.illegal);
    end
  endtask

  function automatic ctl_t base();
    base = '0;
    base.imm = cur_imm;
  endfunction

  task automatic push(input ctl_t c, input logic rdy, input logic z);
    in_t i;
    i.op = cur_op; i.f3 = cur_f3; i.f7 = cur_f7; i.z = z; i.rdy = rdy;
    in_q.push_back(i);
    exp_q.push_back(c);
  endtask

  function automatic logic rbit();
    rbit = 1'($urandom_range(0, 1));
  endfunction

  // Cycle where mem_ready is irrelevant: drive it randomly
  task automatic push_plain(input ctl_t c);
    push(c, rbit(), rbit());
  endtask

  task automatic push_fetch(input int waits);
    ctl_t c;
    for (int i = 0; i <= waits; i++) begin
      c = base();
      c.mem_req = 1'b1; c.b = 2'b10; c.rsrc = 2'b10;
      c.ir_write = (i == waits); c.pc_write = (i == waits);
      push(c, (i == waits), rbit());
    end
  endtask

  function automatic logic [2:0] exec_alu(input logic is_r, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  exec_alu = (is_r && f7) ? 3'b001 : 3'b000;
      3'b010:  exec_alu = 3'b101;
      3'b110:  exec_alu = 3'b011;
      3'b111:  exec_alu = 3'b010;
      default: exec_alu = 3'b000;
    endcase
  endfunction

  // kind: 0 lw, 1 sw, 2 R, 3 I, 4 jal, 5 beq, 6 unsupported opcode
  task automatic add_instr(input int kind, input logic [2:0] f3, input logic f7,
                           input logic z, input int wf, input int wm);
    ctl_t c;
    case (kind)
      0: begin cur_op = 7'b0000011; cur_imm = 2'b00; end
      1: begin cur_op = 7'b0100011; cur_imm = 2'b01; end
      2: begin cur_op = 7'b0110011; cur_imm = 2'b00; end
      3: begin cur_op = 7'b0010011; cur_imm = 2'b00; end
      4: begin cur_op = 7'b1101111; cur_imm = 2'b11; end
      5: begin cur_op = 7'b1100011; cur_imm = 2'b10; end
      default: begin cur_op = 7'b1111111; cur_imm = 2'b00; end
    endcase
    cur_f3 = f3; cur_f7 = f7;
    push_fetch(wf);
    c = base(); c.a = 2'b01; c.b = 2'b01; push_plain(c);
    case (kind)
      0, 1: begin
        c = base(); c.a = 2'b10; c.b = 2'b01; push_plain(c);
        for (int i = 0; i <= wm; i++) begin
          c = base(); c.mem_req = 1'b1; c.adr_src = 1'b1;
          if (kind == 1) begin c.mem_write = 1'b1; c.done = (i == wm); end
          push(c, (i == wm), rbit());
        end
        if (kind == 0) begin
          c = base(); c.rsrc = 2'b01; c.reg_write = 1'b1; c.done = 1'b1; push_plain(c);
        end
      end
      2, 3: begin
        c = base(); c.a = 2'b10; c.b = (kind == 2) ? 2'b00 : 2'b01;
        c.alu = exec_alu(kind == 2, f3, f7); push_plain(c);
        c = base(); c.reg_write = 1'b1; c.done = 1'b1; push_plain(c);
      end
      4: begin
        c = base(); c.a = 2'b01; c.b = 2'b10; c.pc_write = 1'b1; push_plain(c);
        c = base(); c.reg_write = 1'b1; c.done = 1'b1; push_plain(c);
      end
      5: begin
        c = base(); c.a = 2'b10; c.alu = 3'b001; c.pc_write = z; c.done = 1'b1;
        push(c, rbit(), z);
      end
      default: begin
        for (int i = 0; i < 10; i++) begin
          c = base(); c.illegal = 1'b1; push_plain(c);
        end
      end
    endcase
  endtask

  // Called at posedge+1: drive each queued cycle, check at the falling edge
  task automatic run_queue();
    in_t  i;
    ctl_t e;
    while (exp_q.size() > 0) begin
      i = in_q.pop_front();
      e = exp_q.pop_front();
      op = i.op; funct3 = i.f3; funct7b5 = i.f7; zero = i.z; mem_ready = i.rdy;
      @(negedge clk);
      check_ctl($sformatf("cyc%0d_op%b", cyc, i.op), observed(), e);
      cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1; op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
    zero = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    check_ctl("reset_c1", observed(), '0);
    op = 7'b0100011; mem_ready = 1'b1; zero = 1'b1;
    @(negedge clk);
    check_ctl("reset_c2", observed(), '0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed cases
    add_instr(0, 3'b010, 1'b0, 1'b0, 0, 0);
    add_instr(1, 3'b010, 1'b0, 1'b0, 0, 3);
    add_instr(5, 3'b000, 1'b0, 1'b1, 0, 0);
    add_instr(5, 3'b000, 1'b0, 1'b0, 0, 0);
    add_instr(2, 3'b000, 1'b1, 1'b0, 0, 0);
    add_instr(3, 3'b000, 1'b1, 1'b0, 0, 0);
    add_instr(3, 3'b010, 1'b0, 1'b0, 0, 0);
    add_instr(4, 3'b000, 1'b0, 1'b0, 0, 0);
    add_instr(0, 3'b000, 1'b0, 1'b0, 2, 1);
    run_queue();

    // Random instruction stream with random memory stalls
    for (int n = 0; n < 60; n++) begin
      add_instr(int'($urandom_range(0, 5)), 3'($urandom_range(0, 7)), rbit(), rbit(),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end
    run_queue();

    // Reset in the middle of a stalled store
    add_instr(1, 3'b000, 1'b0, 1'b0, 0, 10);
    while (exp_q.size() > 8) begin
      in_t  i;
      ctl_t e;
      i = in_q.pop_front(); e = exp_q.pop_front();
      op = i.op; funct3 = i.f3; funct7b5 = i.f7; zero = i.z; mem_ready = i.rdy;
      @(negedge clk);
      check_ctl($sformatf("pre_rst_cyc%0d", cyc), observed(), e);
      cyc++;
      @(posedge clk); #1;
    end
    exp_q.delete(); in_q.delete();
    reset = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    check_ctl("rst_mid_memwrite", observed(), '0);
    @(posedge clk); #1;
    reset = 1'b0;
    add_instr(2, 3'b111, 1'b0, 1'b0, 0, 0);
    run_queue();

    // Unsupported opcode: sticky illegal, no enables
    add_instr(6, 3'b000, 1'b0, 1'b0, 1, 0);
    run_queue();

    // Recovery through reset
    reset = 1'b1;
    @(negedge clk);
    check_ctl("rst_from_illegal", observed(), '0);
    @(posedge clk); #1;
    reset = 1'b0;
    add_instr(0, 3'b000, 1'b0, 1'b0, 1, 2);
    run_queue();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
